// File: rtl/div_ctrl_if.sv
// Pipeline request, divider and writeback signals of the divide controller.
// slave = controller side, master = pipeline/divider/writeback side.
interface div_ctrl_if #(parameter int DW = 32);
  logic          req_valid_i;
  logic          req_ready_o;
  logic [1:0]    op_i;
  logic [4:0]    rd_i;
  logic [DW-1:0] dividend_i;
  logic [DW-1:0] divisor_i;
  logic          flush_i;
  logic          div_start_o;
  logic [DW-1:0] div_dividend_o;
  logic [DW-1:0] div_divisor_o;
  logic          div_signed_o;
  logic          div_done_i;
  logic [DW-1:0] div_quot_i;
  logic [DW-1:0] div_rem_i;
  logic          wb_valid_o;
  logic          wb_ready_i;
  logic [4:0]    wb_rd_o;
  logic [DW-1:0] wb_data_o;
  logic          busy_o;
  logic          err_o;

  modport slave (
    input  req_valid_i, op_i, rd_i, dividend_i, divisor_i, flush_i,
           div_done_i, div_quot_i, div_rem_i, wb_ready_i,
    output req_ready_o, div_start_o, div_dividend_o, div_divisor_o,
           div_signed_o, wb_valid_o, wb_rd_o, wb_data_o, busy_o, err_o
  );

  modport master (
    output req_valid_i, op_i, rd_i, dividend_i, divisor_i, flush_i,
           div_done_i, div_quot_i, div_rem_i, wb_ready_i,
    input  req_ready_o, div_start_o, div_dividend_o, div_divisor_o,
           div_signed_o, wb_valid_o, wb_rd_o, wb_data_o, busy_o, err_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Divide controller: sequences an iterative divider, short-circuits
// divide-by-zero / signed overflow / repeat operands, and handles flush and timeout.
module div_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  div_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
  state_t state, state_nx;

  logic          run_q, rem_q, sgn_q, err_q;
  logic [4:0]    rd_q;
  logic [DW-1:0] dvd_q, dvs_q, res_q;
  logic          c_vld, c_sgn;
  logic [DW-1:0] c_dvd, c_dvs, c_quot, c_rem;
  logic [CW-1:0] cnt;

  logic          sgn_in, accept, dz, ovf, hit, fast, tmo;
  logic          ld_done, set_err;
  logic [DW-1:0] fast_q, fast_r, fast_res, done_res;

  assign sgn_in = ~bus.op_i[0];
  assign accept = bus.req_valid_i & bus.req_ready_o;
  assign dz     = (bus.divisor_i == '0);
  assign ovf    = sgn_in & (bus.dividend_i == MIN_NEG) & (bus.divisor_i == '1);
  assign hit    = c_vld & (c_dvd == bus.dividend_i) & (c_dvs == bus.divisor_i) &
                  (c_sgn == sgn_in);
  assign fast   = dz | ovf | hit;
  assign tmo    = (cnt == CW'(TIMEOUT - 1)) & ~bus.div_done_i;

  // Short-circuit results; divide-by-zero wins, then overflow, then the cache.
  always_comb begin
    fast_q = c_quot;
    fast_r = c_rem;
    if (dz) begin
      fast_q = '1;
      fast_r = bus.dividend_i;
    end else if (ovf) begin
      fast_q = bus.dividend_i;
      fast_r = '0;
    end
  end

  assign fast_res = bus.op_i[1] ? fast_r : fast_q;
  assign done_res = rem_q ? bus.div_rem_i : bus.div_quot_i;

  always_comb begin
    state_nx = state;
    ld_done  = 1'b0;
    set_err  = 1'b0;
    case (state)
      IDLE:  if (accept) state_nx = fast ? RESP : ISSUE;
      ISSUE: state_nx = bus.flush_i ? DRAIN : WAIT;
      WAIT: begin
        if (bus.flush_i) begin
          state_nx = bus.div_done_i ? IDLE : DRAIN;
        end else if (bus.div_done_i) begin
          state_nx = RESP;
          ld_done  = 1'b1;
        end else if (tmo) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end
      end
      DRAIN: begin
        if (bus.div_done_i) begin
          state_nx = IDLE;
        end else if (tmo) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end
      end
      RESP:    if (bus.flush_i || bus.wb_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      run_q  <= 1'b0;
      rem_q  <= 1'b0;
      sgn_q  <= 1'b0;
      rd_q   <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      res_q  <= '0;
      c_vld  <= 1'b0;
      c_sgn  <= 1'b0;
      c_dvd  <= '0;
      c_dvs  <= '0;
      c_quot <= '0;
      c_rem  <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      run_q <= 1'b1;
      if (accept) begin
        rem_q <= bus.op_i[1];
        sgn_q <= sgn_in;
        rd_q  <= bus.rd_i;
        dvd_q <= bus.dividend_i;
        dvs_q <= bus.divisor_i;
        if (fast) res_q <= fast_res;
      end
      if (ld_done) begin
        res_q  <= done_res;
        c_vld  <= 1'b1;
        c_sgn  <= sgn_q;
        c_dvd  <= dvd_q;
        c_dvs  <= dvs_q;
        c_quot <= bus.div_quot_i;
        c_rem  <= bus.div_rem_i;
      end
      // Counts cycles spent waiting on the divider; zero everywhere else.
      cnt   <= (state == WAIT || state == DRAIN) ? cnt + 1'b1 : '0;
      err_q <= err_q | set_err;
    end
  end

  assign bus.req_ready_o    = run_q & (state == IDLE) & ~bus.flush_i;
  assign bus.div_start_o    = (state == ISSUE);
  assign bus.div_dividend_o = dvd_q;
  assign bus.div_divisor_o  = dvs_q;
  assign bus.div_signed_o   = sgn_q;
  assign bus.wb_valid_o     = (state == RESP);
  assign bus.wb_rd_o        = rd_q;
  assign bus.wb_data_o      = res_q;
  assign bus.busy_o         = (state != IDLE);
  assign bus.err_o          = err_q;
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Parameters
REQ-001 DW, 32, operand/result width.
REQ-002 TIMEOUT, 64, max cycles in WAIT before error abort.

Interface
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 req_valid_i  in  1  pipeline divide request.
REQ-006 req_ready_o  out  1  controller can accept a request.
REQ-007 op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 rd_i  in  5  destination register tag.
REQ-009 dividend_i / divisor_i  in  DW each  operands.
REQ-010 flush_i  in  1  pipeline kill of the in-flight op.
REQ-011 div_start_o  out  1  one-cycle start pulse to the divider.
REQ-012 div_dividend_o / div_divisor_o  out  DW each  divider operands, held stable from start until done.
REQ-013 div_signed_o  out  1  signed mode to the divider.
REQ-014 div_done_i  in  1  divider result valid, one-cycle pulse.
REQ-015 div_quot_i / div_rem_i  in  DW each  divider results.
REQ-016 wb_valid_o  out  1  writeback valid.
REQ-017 wb_ready_i  in  1  writeback accepted.
REQ-018 wb_rd_o  out  5  writeback tag.
REQ-019 wb_data_o  out  DW  writeback data.
REQ-020 busy_o  out  1  high in every state except IDLE.
REQ-021 err_o  out  1  sticky timeout flag; cleared only by reset.

Function
REQ-022 States: IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-023 req_ready_o = (state==IDLE) & ~flush_i.
- Accept = req_valid_i & req_ready_o.
- Accept latches op, rd, operands and signed = ~op_i[0].
REQ-024 Divide-by-zero (divisor 0), on accept: IDLE->RESP, no div_start_o.
- Quotient = all ones; remainder = dividend.
REQ-025 Signed overflow (signed, dividend = 1<<(DW-1), divisor = all ones), on accept: IDLE->RESP, no div_start_o.
- Quotient = dividend; remainder = 0.
REQ-026 Cache hit, on accept: IDLE->RESP, no div_start_o, data taken from the cache.
- Hit = cache valid & operands equal & signed equal.
REQ-027 Any other accept: IDLE->ISSUE.
- ISSUE asserts div_start_o for exactly one cycle, then ->WAIT.
REQ-028 WAIT, div_done_i: latch the selected result, update the cache, ->RESP.
- Cache stores operands, signed flag, quotient and remainder.
REQ-029 Result selection: op_i[1]=0 gives quotient; op_i[1]=1 gives remainder.
REQ-030 RESP holds wb_valid_o=1 with stable wb_rd_o/wb_data_o until wb_ready_i; then ->IDLE.
REQ-031 Latency from accept to wb_valid_o:
- Special case or cache hit: 1 cycle.
- Normal op: divider latency + 2 cycles.
REQ-032 flush_i in ISSUE or WAIT ->DRAIN.
- A start pulse already issued is not retracted.
- DRAIN waits for div_done_i, discards the result, leaves the cache unchanged, then ->IDLE.
REQ-033 flush_i in RESP: drop wb_valid_o next cycle, ->IDLE.
REQ-034 flush_i and req_valid_i in the same cycle in IDLE: the request is ignored.
REQ-035 flush_i and div_done_i in the same cycle in WAIT: the result is discarded, ->IDLE.
REQ-036 WAIT/DRAIN cycle counter: at TIMEOUT cycles with no div_done_i, set err_o and ->IDLE, with no writeback.
- Counter clears on entry to WAIT.
REQ-037 div_done_i outside WAIT/DRAIN is ignored.

Reset
REQ-038 rst_n low, at any time including mid-WAIT:
- State ->IDLE.
- Cache valid cleared; counter cleared.
- All outputs 0: req_ready_o rises only after reset is released.
- No result is delivered afterwards.

Verification
REQ-039 DIV 0xFFFFFFF9 / 0x00000002: one div_start_o with div_signed_o=1; divider returns q=0xFFFFFFFD, r=0xFFFFFFFF -> wb_data_o=0xFFFFFFFD.
REQ-040 REM with the same operands right after: no div_start_o -> wb_valid_o 1 cycle after accept, wb_data_o=0xFFFFFFFF.
REQ-041 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. All with no div_start_o.
REQ-042 flush_i 3 cycles after start: no wb_valid_o, req_ready_o low until div_done_i, then the same operands miss the cache.
REQ-043 div_done_i withheld for 64 cycles: err_o=1, state IDLE; wb_ready_i=0 for 5 cycles in RESP keeps wb_data_o stable.
REQ-044 rst_n low mid-WAIT, late div_done_i after release: all outputs 0, no wb_valid_o.
